// File: rtl/runway_pkg.sv
// Shared types and direction-select encodings for the runway light arbiter.
package runway_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_L = 2'd1,
        GRANT_R = 2'd2,
        CALM    = 2'd3
    } state_t;

    localparam logic [1:0] SW_CALM = 2'b00;
    localparam logic [1:0] SW_R2L  = 2'b01;
    localparam logic [1:0] SW_L2R  = 2'b10;

    // Moore decode of the runway select; 2'b11 is unreachable by construction.
    function automatic logic [1:0] sw_of(input state_t s);
        case (s)
            GRANT_L: sw_of = SW_L2R;
            GRANT_R: sw_of = SW_R2L;
            default: sw_of = SW_CALM;
        endcase
    endfunction

endpackage

// File: rtl/runway_hold_timer.sv
// Loadable down-counter that times both the grant window and the calm guard.
module runway_hold_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // load beats hold; an idle counter parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/runway_arbiter.sv
// Round-robin arbiter sharing the runway light block between the left and
// right approaches, with bounded grant windows and a calm guard between grants.
module runway_arbiter
    import runway_pkg::*;
#(
    parameter int HOLD_CYC = 8,
    parameter int CALM_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_l,
    input  logic       req_r,
    input  logic       emerg,
    output logic [1:0] sw,
    output logic       gnt_l,
    output logic       gnt_r,
    output logic       busy,
    output logic [7:0] n_served
);

    localparam int MAX_CYC = (HOLD_CYC > CALM_CYC) ? HOLD_CYC : CALM_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CALM_V = CNT_W'(CALM_CYC - 1);

    // Handshake: req_x is a level held by the requester for as long as it wants
    // the runway; gnt_x rises the cycle after a winning sample and stays high
    // until the window expires, req_x is sampled low, or emerg is sampled high.
    state_t           state;
    state_t           next_state;
    state_t           arb_state;
    logic             last_l;
    logic             served;
    logic             tmr_load;
    logic             tmr_hold;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    runway_hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (tmr_hold),
        .zero     (tmr_zero)
    );

    always_comb begin
        arb_state = IDLE;
        if (req_l && (!req_r || !last_l)) begin
            arb_state = GRANT_L;
        end else if (req_r) begin
            arb_state = GRANT_R;
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_hold   = 1'b0;
        tmr_val    = '0;
        served     = 1'b0;
        if (emerg) begin
            // Reloading every cycle pins the guard at full length until emerg drops.
            next_state = CALM;
            tmr_load   = 1'b1;
            tmr_val    = CALM_V;
        end else begin
            case (state)
                IDLE: begin
                    next_state = arb_state;
                    tmr_hold   = 1'b1;
                    if (arb_state != IDLE) begin
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_V;
                    end
                end
                GRANT_L: begin
                    if (tmr_zero || !req_l) begin
                        next_state = CALM;
                        tmr_load   = 1'b1;
                        tmr_val    = CALM_V;
                        served     = 1'b1;
                    end
                end
                GRANT_R: begin
                    if (tmr_zero || !req_r) begin
                        next_state = CALM;
                        tmr_load   = 1'b1;
                        tmr_val    = CALM_V;
                        served     = 1'b1;
                    end
                end
                CALM: begin
                    if (tmr_zero) begin
                        next_state = arb_state;
                        if (arb_state != IDLE) begin
                            tmr_load = 1'b1;
                            tmr_val  = HOLD_V;
                        end else begin
                            tmr_hold = 1'b1;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are registered from next_state so they always equal decode(state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_l   <= 1'b0;
            n_served <= 8'd0;
            sw       <= SW_CALM;
            gnt_l    <= 1'b0;
            gnt_r    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= next_state;
            if (served) begin
                n_served <= n_served + 8'd1;
                last_l   <= (state == GRANT_L);
            end
            sw    <= sw_of(next_state);
            gnt_l <= (next_state == GRANT_L);
            gnt_r <= (next_state == GRANT_R);
            busy  <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_runway_arbiter.sv
// Directed bench for runway_arbiter with HOLD_CYC=4, CALM_CYC=2.
module tb_runway_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_l;
    logic       req_r;
    logic       emerg;
    logic [1:0] sw;
    logic       gnt_l;
    logic       gnt_r;
    logic       busy;
    logic [7:0] n_served;

    int checks   = 0;
    int failures = 0;

    runway_arbiter #(.HOLD_CYC(4), .CALM_CYC(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_l    (req_l),
        .req_r    (req_r),
        .emerg    (emerg),
        .sw       (sw),
        .gnt_l    (gnt_l),
        .gnt_r    (gnt_r),
        .busy     (busy),
        .n_served (n_served)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {sw, gnt_l, gnt_r, busy}; grants follow from the expected select.
    task automatic check_out(input string tag, input logic [1:0] exp_sw, input logic exp_busy);
        logic [7:0] exp;
        exp = {3'b000, exp_sw, (exp_sw == 2'b10), (exp_sw == 2'b01), exp_busy};
        check(tag, {3'b000, sw, gnt_l, gnt_r, busy}, exp);
    endtask

    logic [1:0] seq_c [16];

    initial begin
        seq_c = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                  2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                  2'b10, 2'b10, 2'b10, 2'b10};
        reset = 1'b1;
        req_l = 1'b0;
        req_r = 1'b0;
        emerg = 1'b0;
        step();
        step();
        check_out("reset_out", 2'b00, 1'b0);
        check("reset_ns", n_served, 8'd0);
        reset = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("idle_out", 2'b00, 1'b0);
            check("idle_ns", n_served, 8'd0);
        end

        // Single left requester held high: 4 grant, 2 calm, 4 grant.
        req_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("l_hold1", 2'b10, 1'b1);
            check("l_hold1_ns", n_served, 8'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("l_calm", 2'b00, 1'b1);
            check("l_calm_ns", n_served, 8'd1);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("l_hold2", 2'b10, 1'b1);
        end
        // Asynchronous reset mid-grant drops everything at once.
        reset = 1'b1;
        #1;
        check_out("rst_mid_out", 2'b00, 1'b0);
        check("rst_mid_ns", n_served, 8'd0);
        step();

        // Both requesters high from reset release: strict L/R alternation.
        req_l = 1'b1;
        req_r = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check_out($sformatf("rr_%0d", i), seq_c[i], 1'b1);
        end
        check("rr_ns", n_served, 8'd2);

        req_l = 1'b0;
        req_r = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Right pulse of two cycles: early release then back to idle.
        req_r = 1'b1;
        step();
        check_out("r_pulse1", 2'b01, 1'b1);
        step();
        check_out("r_pulse2", 2'b01, 1'b1);
        req_r = 1'b0;
        step();
        check_out("r_rel_calm1", 2'b00, 1'b1);
        check("r_rel_ns", n_served, 8'd1);
        step();
        check_out("r_rel_calm2", 2'b00, 1'b1);
        step();
        check_out("r_rel_idle", 2'b00, 1'b0);
        check("r_rel_idle_ns", n_served, 8'd1);

        // Emergency abort in cycle 2 of a left grant; left retries first.
        req_l = 1'b1;
        step();
        check_out("em_g1", 2'b10, 1'b1);
        step();
        check_out("em_g2", 2'b10, 1'b1);
        emerg = 1'b1;
        req_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("em_hold", 2'b00, 1'b1);
            check("em_hold_ns", n_served, 8'd1);
        end
        emerg = 1'b0;
        step();
        check_out("em_tail", 2'b00, 1'b1);
        step();
        check_out("em_retry_l", 2'b10, 1'b1);
        check("em_retry_ns", n_served, 8'd1);
        req_l = 1'b0;
        step();
        check_out("em_rel_calm", 2'b00, 1'b1);
        check("em_rel_ns", n_served, 8'd2);
        step();
        check_out("em_rel_calm2", 2'b00, 1'b1);
        step();
        check_out("em_then_r", 2'b01, 1'b1);

        // Random requests: select never 11 and grants never both high.
        for (int i = 0; i < 500; i++) begin
            req_l = 1'($urandom_range(0, 1));
            req_r = 1'($urandom_range(0, 1));
            emerg = ($urandom_range(0, 15) == 0);
            step();
            check("rand_sw11", {7'd0, (sw == 2'b11)}, 8'd0);
            check("rand_both", {7'd0, (gnt_l & gnt_r)}, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
